decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised, flow-controlled RV32I(M) instruction decode stage that sits between fetch and issue. It replaces fixed-latency, clock-enable-stalled decoding with a valid/ready handshake and a DEPTH-entry output queue, and it supports pipeline flush. It adds operand-usage flags for hazard detection and stricter illegal-encoding checks.

## Interface
- XLEN, 32, data/address width (PC, immediate)
- REG_ADDR_W, 5, register index width
- DEPTH, 2, output queue entries (power of two, ≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous discard of all queued and incoming instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  issue consumes head
- out_opcode  out  opcodes  decoded operation (core_config_pkg enum)
- out_rs1, out_rs2, out_rd  out  REG_ADDR_W  register indices
- out_rs1_en, out_rs2_en, out_rd_en  out  1  operand actually read/written
- out_imm  out  XLEN  sign/zero-extended immediate
- out_pc  out  XLEN  address of head instruction
- out_illegal  out  1  head is an illegal encoding

## Operation
- Accept on in_valid && in_ready; decode is combinational on in_instr; the result, in_pc and illegal flag are written to the queue tail the same edge.
- in_ready = (count < DEPTH) || (out_valid && out_ready); a simultaneous push and pop on a full queue is allowed.
- Pop on out_valid && out_ready. Head outputs come straight from queue storage.
- When empty: out_valid=0, out_opcode=i_NOP, all other outputs 0.
- Immediate formats: I, S, B, U, J per RV32 spec; B/J immediate bit 0 = 0; U = instr[31:12]<<12; CSR*I puts zimm (instr[19:15]) in out_imm zero-extended and sets rs1_en=0.
- Enables: R rs1/rs2/rd; I rs1/rd; S,B rs1/rs2; U,J rd; ECALL/EBREAK/MRET/FENCE all 0. rd_en=0 when rd=x0.
- Illegal (out_opcode=i_NOP, out_illegal=1, all enables 0): unknown major opcode; instr==0x00000000 or 0xFFFFFFFF; unused funct3; R funct7 other than 0000000/0100000 (SUB/SRA only)/0000001 (gated); SLLI with funct7≠0; SRLI/SRAI with funct7 ∉ {0000000,0100000}; SYSTEM funct3=000 with imm ∉ {0x000,0x001,0x302} or rs1/rd≠0; instr[1:0]≠11.
- Illegal instructions still occupy a queue entry and keep their PC so issue can trap precisely.
- flush: count, read and write pointers cleared next edge; in_ready forced 0 during flush; a push in the flush cycle is dropped; a pop in the flush cycle is ignored.

## Timing
- Latency 1: an instruction accepted at edge N has out_valid=1 after edge N (queue empty before).
- Throughput 1/cycle with out_ready held high, for any DEPTH.
- Full-throughput back-pressure: out_ready low → queue fills in DEPTH cycles; in_ready then drops combinationally.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; count is $clog2(DEPTH+1) bits wide.
- Reset (asynchronous): count=0, pointers=0, so in_ready=1, out_valid=0, out_opcode=i_NOP, all data outputs 0. Reset mid-stream discards all entries.
- Flush asserted at edge N: out_valid=0 after N; in_ready=1 again in the cycle after flush deasserts.

## Configuration
- RV32M_EN defined: funct7=0000001 under OP decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (rs1/rs2/rd enabled).
- RV32M_EN undefined: the same encodings are illegal (i_NOP, out_illegal=1); the remaining decode is unchanged.

## Test plan
- Reset, then push 0x002081B3 @pc 0x100 → next cycle out_valid=1, i_ADD, rs1=1 rs2=2 rd=3, all enables 1, out_pc=0x100.
- Stream 0x00500093, 0x008000EF, 0x0020A223 with out_ready=1 → i_ADDI imm=5 rd=1; i_JAL imm=8 rd=1; i_SW rs1=1 rs2=2 imm=4 rd_en=0; one per cycle.
- Hold out_ready=0 with DEPTH=2 and push 3 instructions → in_ready=0 after 2; raise out_ready → the third is accepted in the same cycle as the first pop, and order is preserved.
- Push 0x00000000, 0x02209093 (SLLI with funct7≠0), 0x00100073 → illegal, illegal, i_EBREAK with all enables 0.
- Push 0x022081B3 → i_MUL with RV32M_EN defined; out_illegal=1 and i_NOP without it.
- Queue 2 entries, then assert flush for 1 cycle with in_valid=1 → out_valid=0 next cycle, the pushed word is dropped, and a later push decodes normally.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I(M) decode stage: valid/ready handshake into a DEPTH-entry output queue, with flush.
// Optional build macro RV32M_EN decodes the M extension; without it those encodings are illegal.
package core_config_pkg;
    typedef enum logic [5:0] {
        i_NOP, i_LUI, i_AUIPC, i_JAL, i_JALR,
        i_BEQ, i_BNE, i_BLT, i_BGE, i_BLTU, i_BGEU,
        i_LB, i_LH, i_LW, i_LBU, i_LHU, i_SB, i_SH, i_SW,
        i_ADDI, i_SLTI, i_SLTIU, i_XORI, i_ORI, i_ANDI, i_SLLI, i_SRLI, i_SRAI,
        i_ADD, i_SUB, i_SLL, i_SLT, i_SLTU, i_XOR, i_SRL, i_SRA, i_OR, i_AND,
        i_FENCE, i_ECALL, i_EBREAK, i_MRET,
        i_CSRRW, i_CSRRS, i_CSRRC, i_CSRRWI, i_CSRRSI, i_CSRRCI,
        i_MUL, i_MULH, i_MULHSU, i_MULHU, i_DIV, i_DIVU, i_REM, i_REMU
    } opcodes;
endpackage

module decode_stage
    import core_config_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output opcodes                out_opcode,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rs1_en,
    output logic                  out_rs2_en,
    output logic                  out_rd_en,
    output logic [XLEN-1:0]       out_imm,
    output logic [XLEN-1:0]       out_pc,
    output logic                  out_illegal
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        opcodes                op;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rs1_en;
        logic                  rs2_en;
        logic                  rd_en;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic                  illegal;
    } entry_t;

    logic [6:0]      major;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

    assign major  = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = XLEN'($signed(in_instr[31:20]));
    assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    assign imm_z  = XLEN'(in_instr[19:15]);

    entry_t     dec;
    logic       bad;
    logic [2:0] en;

    // en is {rs1, rs2, rd}
    always_comb begin
        dec     = '0;
        dec.op  = i_NOP;
        dec.rs1 = REG_ADDR_W'(in_instr[19:15]);
        dec.rs2 = REG_ADDR_W'(in_instr[24:20]);
        dec.rd  = REG_ADDR_W'(in_instr[11:7]);
        dec.pc  = in_pc;
        dec.imm = imm_i;
        bad     = 1'b0;
        en      = 3'b000;
        case (major)
            7'b0110111: begin dec.op = i_LUI;   dec.imm = imm_u; en = 3'b001; end
            7'b0010111: begin dec.op = i_AUIPC; dec.imm = imm_u; en = 3'b001; end
            7'b1101111: begin dec.op = i_JAL;   dec.imm = imm_j; en = 3'b001; end
            7'b1100111: begin
                dec.op = i_JALR; en = 3'b101;
                if (funct3 != 3'b000) bad = 1'b1;
            end
            7'b1100011: begin
                dec.imm = imm_b; en = 3'b110;
                case (funct3)
                    3'b000:  dec.op = i_BEQ;
                    3'b001:  dec.op = i_BNE;
                    3'b100:  dec.op = i_BLT;
                    3'b101:  dec.op = i_BGE;
                    3'b110:  dec.op = i_BLTU;
                    3'b111:  dec.op = i_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            7'b0000011: begin
                en = 3'b101;
                case (funct3)
                    3'b000:  dec.op = i_LB;
                    3'b001:  dec.op = i_LH;
                    3'b010:  dec.op = i_LW;
                    3'b100:  dec.op = i_LBU;
                    3'b101:  dec.op = i_LHU;
                    default: bad = 1'b1;
                endcase
            end
            7'b0100011: begin
                dec.imm = imm_s; en = 3'b110;
                case (funct3)
                    3'b000:  dec.op = i_SB;
                    3'b001:  dec.op = i_SH;
                    3'b010:  dec.op = i_SW;
                    default: bad = 1'b1;
                endcase
            end
            7'b0010011: begin
                en = 3'b101;
                case (funct3)
                    3'b000: dec.op = i_ADDI;
                    3'b010: dec.op = i_SLTI;
                    3'b011: dec.op = i_SLTIU;
                    3'b100: dec.op = i_XORI;
                    3'b110: dec.op = i_ORI;
                    3'b111: dec.op = i_ANDI;
                    3'b001: begin dec.op = i_SLLI; bad = (funct7 != 7'b0000000); end
                    3'b101: begin
                        if (funct7 == 7'b0000000)      dec.op = i_SRLI;
                        else if (funct7 == 7'b0100000) dec.op = i_SRAI;
                        else                           bad = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                en = 3'b111;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: dec.op = i_ADD;
                        3'b001: dec.op = i_SLL;
                        3'b010: dec.op = i_SLT;
                        3'b011: dec.op = i_SLTU;
                        3'b100: dec.op = i_XOR;
                        3'b101: dec.op = i_SRL;
                        3'b110: dec.op = i_OR;
                        3'b111: dec.op = i_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    case (funct3)
                        3'b000:  dec.op = i_SUB;
                        3'b101:  dec.op = i_SRA;
                        default: bad = 1'b1;
                    endcase
                end
`ifdef RV32M_EN
                else if (funct7 == 7'b0000001) begin
                    case (funct3)
                        3'b000: dec.op = i_MUL;
                        3'b001: dec.op = i_MULH;
                        3'b010: dec.op = i_MULHSU;
                        3'b011: dec.op = i_MULHU;
                        3'b100: dec.op = i_DIV;
                        3'b101: dec.op = i_DIVU;
                        3'b110: dec.op = i_REM;
                        3'b111: dec.op = i_REMU;
                    endcase
                end
`endif
                else bad = 1'b1;
            end
            7'b0001111: begin
                dec.op = i_FENCE;
                if (funct3 != 3'b000) bad = 1'b1;
            end
            7'b1110011: begin
                case (funct3)
                    3'b000: begin
                        if (in_instr[19:15] != 5'd0 || in_instr[11:7] != 5'd0) bad = 1'b1;
                        else if (in_instr[31:20] == 12'h000) dec.op = i_ECALL;
                        else if (in_instr[31:20] == 12'h001) dec.op = i_EBREAK;
                        else if (in_instr[31:20] == 12'h302) dec.op = i_MRET;
                        else bad = 1'b1;
                    end
                    3'b001: begin dec.op = i_CSRRW;  en = 3'b101; end
                    3'b010: begin dec.op = i_CSRRS;  en = 3'b101; end
                    3'b011: begin dec.op = i_CSRRC;  en = 3'b101; end
                    3'b101: begin dec.op = i_CSRRWI; en = 3'b001; dec.imm = imm_z; end
                    3'b110: begin dec.op = i_CSRRSI; en = 3'b001; dec.imm = imm_z; end
                    3'b111: begin dec.op = i_CSRRCI; en = 3'b001; dec.imm = imm_z; end
                    default: bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (in_instr == 32'h0000_0000 || in_instr == 32'hFFFF_FFFF || in_instr[1:0] != 2'b11)
            bad = 1'b1;
        if (in_instr[11:7] == 5'd0) en[0] = 1'b0;
        if (bad) begin
            dec.op  = i_NOP;
            en      = 3'b000;
        end
        {dec.rs1_en, dec.rs2_en, dec.rd_en} = en;
        dec.illegal = bad;
    end

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;
    entry_t           head;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (count != '0);
    assign in_ready  = !flush && ((count < CNT_W'(DEPTH)) || (out_valid && out_ready));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // Stale storage is masked so an empty queue presents NOP with zeroed fields.
    assign head        = mem[rd_ptr];
    assign out_opcode  = out_valid ? head.op : i_NOP;
    assign out_rs1     = out_valid ? head.rs1 : '0;
    assign out_rs2     = out_valid ? head.rs2 : '0;
    assign out_rd      = out_valid ? head.rd : '0;
    assign out_rs1_en  = out_valid && head.rs1_en;
    assign out_rs2_en  = out_valid && head.rs2_en;
    assign out_rd_en   = out_valid && head.rd_en;
    assign out_imm     = out_valid ? head.imm : '0;
    assign out_pc      = out_valid ? head.pc : '0;
    assign out_illegal = out_valid && head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table-driven reference decoder plus a queue model checked every cycle.
module tb_decode_stage;
    import core_config_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    opcodes      out_opcode;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rs1_en, out_rs2_en, out_rd_en, out_illegal;
    logic [31:0] out_imm, out_pc;

    decode_stage #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_en(out_rd_en),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef enum {F_R, F_I, F_S, F_B, F_U, F_J, F_Z, F_N} fmt_t;
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        opcodes      op;
        fmt_t        fmt;
    } rule_t;
    typedef struct {
        opcodes      op;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  en;
        logic [31:0] imm, pc;
        logic        ill;
    } exp_t;

    rule_t rules[$];
    exp_t  mq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    run_cmp = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rule(input logic [31:0] mask, input logic [31:0] match, input opcodes op, input fmt_t f);
        rule_t r;
        r.mask = mask; r.match = match; r.op = op; r.fmt = f;
        rules.push_back(r);
    endtask

    function automatic exp_t decode_ref(input logic [31:0] w, input logic [31:0] pc);
        exp_t               e;
        bit                 hit;
        fmt_t               f;
        logic signed [31:0] sw;
        hit = 0; f = F_N; sw = w;
        e.op = i_NOP; e.pc = pc; e.en = 3'b000; e.ill = 0;
        e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        e.imm = sw >>> 20;
        foreach (rules[k])
            if (!hit && (w & rules[k].mask) == rules[k].match) begin
                hit = 1; e.op = rules[k].op; f = rules[k].fmt;
            end
        if (!hit || w == 32'h0 || w == 32'hFFFF_FFFF) begin
            e.op = i_NOP; e.ill = 1;
            return e;
        end
        case (f)
            F_R: e.en = 3'b111;
            F_I: e.en = 3'b101;
            F_S: begin e.en = 3'b110; e.imm = ((sw >>> 20) & ~32'h1F) | 32'(w[11:7]); end
            F_B: begin e.en = 3'b110; e.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0}; end
            F_U: begin e.en = 3'b001; e.imm = w & 32'hFFFF_F000; end
            F_J: begin e.en = 3'b001; e.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; end
            F_Z: begin e.en = 3'b001; e.imm = 32'(w[19:15]); end
            F_N: e.en = 3'b000;
        endcase
        if (e.rd == 5'd0) e.en[0] = 1'b0;
        return e;
    endfunction

    task automatic build_rules();
        rule(32'h7F, 32'h37, i_LUI, F_U);     rule(32'h7F, 32'h17, i_AUIPC, F_U);
        rule(32'h7F, 32'h6F, i_JAL, F_J);     rule(32'h707F, 32'h67, i_JALR, F_I);
        rule(32'h707F, 32'h0063, i_BEQ, F_B); rule(32'h707F, 32'h1063, i_BNE, F_B);
        rule(32'h707F, 32'h4063, i_BLT, F_B); rule(32'h707F, 32'h5063, i_BGE, F_B);
        rule(32'h707F, 32'h6063, i_BLTU, F_B); rule(32'h707F, 32'h7063, i_BGEU, F_B);
        rule(32'h707F, 32'h0003, i_LB, F_I);  rule(32'h707F, 32'h1003, i_LH, F_I);
        rule(32'h707F, 32'h2003, i_LW, F_I);  rule(32'h707F, 32'h4003, i_LBU, F_I);
        rule(32'h707F, 32'h5003, i_LHU, F_I);
        rule(32'h707F, 32'h0023, i_SB, F_S);  rule(32'h707F, 32'h1023, i_SH, F_S);
        rule(32'h707F, 32'h2023, i_SW, F_S);
        rule(32'h707F, 32'h0013, i_ADDI, F_I); rule(32'h707F, 32'h2013, i_SLTI, F_I);
        rule(32'h707F, 32'h3013, i_SLTIU, F_I); rule(32'h707F, 32'h4013, i_XORI, F_I);
        rule(32'h707F, 32'h6013, i_ORI, F_I);  rule(32'h707F, 32'h7013, i_ANDI, F_I);
        rule(32'hFE00707F, 32'h1013, i_SLLI, F_I); rule(32'hFE00707F, 32'h5013, i_SRLI, F_I);
        rule(32'hFE00707F, 32'h40005013, i_SRAI, F_I);
        rule(32'hFE00707F, 32'h0033, i_ADD, F_R); rule(32'hFE00707F, 32'h40000033, i_SUB, F_R);
        rule(32'hFE00707F, 32'h1033, i_SLL, F_R); rule(32'hFE00707F, 32'h2033, i_SLT, F_R);
        rule(32'hFE00707F, 32'h3033, i_SLTU, F_R); rule(32'hFE00707F, 32'h4033, i_XOR, F_R);
        rule(32'hFE00707F, 32'h5033, i_SRL, F_R); rule(32'hFE00707F, 32'h40005033, i_SRA, F_R);
        rule(32'hFE00707F, 32'h6033, i_OR, F_R);  rule(32'hFE00707F, 32'h7033, i_AND, F_R);
`ifdef RV32M_EN
        rule(32'hFE00707F, 32'h02000033, i_MUL, F_R);  rule(32'hFE00707F, 32'h02001033, i_MULH, F_R);
        rule(32'hFE00707F, 32'h02002033, i_MULHSU, F_R); rule(32'hFE00707F, 32'h02003033, i_MULHU, F_R);
        rule(32'hFE00707F, 32'h02004033, i_DIV, F_R);  rule(32'hFE00707F, 32'h02005033, i_DIVU, F_R);
        rule(32'hFE00707F, 32'h02006033, i_REM, F_R);  rule(32'hFE00707F, 32'h02007033, i_REMU, F_R);
`endif
        rule(32'h707F, 32'h000F, i_FENCE, F_N);
        rule(32'hFFFF_FFFF, 32'h00000073, i_ECALL, F_N);
        rule(32'hFFFF_FFFF, 32'h00100073, i_EBREAK, F_N);
        rule(32'hFFFF_FFFF, 32'h30200073, i_MRET, F_N);
        rule(32'h707F, 32'h1073, i_CSRRW, F_I);  rule(32'h707F, 32'h2073, i_CSRRS, F_I);
        rule(32'h707F, 32'h3073, i_CSRRC, F_I);  rule(32'h707F, 32'h5073, i_CSRRWI, F_Z);
        rule(32'h707F, 32'h6073, i_CSRRSI, F_Z); rule(32'h707F, 32'h7073, i_CSRRCI, F_Z);
    endtask

    // Queue model: one push/pop decision per rising edge from the bench's own occupancy.
    int m_sz;
    bit m_rdy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mq.delete();
        else begin
            m_sz  = mq.size();
            m_rdy = !flush && (m_sz < DEPTH || (m_sz > 0 && out_ready));
            if (flush) mq.delete();
            else begin
                if (m_sz > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && m_rdy) mq.push_back(decode_ref(in_instr, in_pc));
            end
        end
    end

    int   c_sz;
    exp_t c_e;
    always @(negedge clk) begin
        if (run_cmp) begin
            c_sz = mq.size();
            chk("in_ready", in_ready, !flush && (c_sz < DEPTH || (c_sz > 0 && out_ready)));
            if (c_sz == 0) begin
                chk("empty", {out_valid, out_opcode, out_rs1, out_rs2, out_rd, out_rs1_en, out_rs2_en,
                              out_rd_en, out_imm, out_pc, out_illegal},
                    {1'b0, i_NOP, 5'd0, 5'd0, 5'd0, 3'b000, 32'd0, 32'd0, 1'b0});
            end else begin
                c_e = mq[0];
                chk("head_ctl", {out_valid, out_opcode, out_rs1_en, out_rs2_en, out_rd_en, out_illegal, out_pc},
                    {1'b1, c_e.op, c_e.en, c_e.ill, c_e.pc});
                if (!c_e.ill)
                    chk("head_fields", {out_rs1, out_rs2, out_rd, out_imm}, {c_e.rs1, c_e.rs2, c_e.rd, c_e.imm});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        bit done;
        done = 0;
        in_valid = 1; in_instr = w; in_pc = pc;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            step();
        end
        in_valid = 0;
        chk("send_accept", done, 1'b1);
    endtask

    task automatic pop_all();
        step();
        out_ready = 1;
        for (int i = 0; i < DEPTH + 4; i++) begin
            step();
            if (!out_valid) break;
        end
        out_ready = 0;
        chk("drain", out_valid, 1'b0);
    endtask

    logic [31:0] misc[$] = '{32'hFFFF_FFFF, 32'h0000A063, 32'h40001033, 32'h00200073, 32'h00100173,
                             32'h00500092, 32'h4020D093, 32'h30200073, 32'h0000100F, 32'h3400D0F3,
                             32'h123450B7, 32'hFE000EE3, 32'h00000073, 32'h40208133, 32'h0220C1B3,
                             32'h00002183, 32'hFFF0C093, 32'h02209093, 32'h0020A223, 32'h00C0006F};

    initial begin
        exp_t e;
        int   idx;
        bit   acc;
        rst_n = 0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        build_rules();

        e = decode_ref(32'h00500093, 0);
        chk("pin_addi", {e.op, e.imm, e.en}, {i_ADDI, 32'd5, 3'b101});
        e = decode_ref(32'hFE000EE3, 0);
        chk("pin_beq_neg", {e.op, e.imm}, {i_BEQ, 32'hFFFF_FFFC});
        e = decode_ref(32'h123450B7, 0);
        chk("pin_lui", e.imm, 32'h1234_5000);
        e = decode_ref(32'h0020A223, 0);
        chk("pin_sw", {e.op, e.imm, e.en}, {i_SW, 32'd4, 3'b110});
        e = decode_ref(32'h00100173, 0);
        chk("pin_ebreak_rd", e.ill, 1'b1);
        e = decode_ref(32'h3400D0F3, 0);
        chk("pin_csrrwi", {e.op, e.imm, e.en}, {i_CSRRWI, 32'd1, 3'b001});

        repeat (3) step();
        rst_n = 1;
        run_cmp = 1;
        @(negedge clk);
        chk("rst_state", {in_ready, out_valid, out_opcode, out_imm, out_pc}, {1'b1, 1'b0, i_NOP, 32'd0, 32'd0});
        step();

        send(32'h002081B3, 32'h100);
        @(negedge clk);
        chk("add_head", {out_valid, out_opcode, out_rs1, out_rs2, out_rd, out_rs1_en, out_rs2_en, out_rd_en, out_pc},
            {1'b1, i_ADD, 5'd1, 5'd2, 5'd3, 3'b111, 32'h100});
        pop_all();

        out_ready = 1;
        in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h200;
        step();
        in_instr = 32'h008000EF; in_pc = 32'h204;
        @(negedge clk);
        chk("stream_addi", {out_opcode, out_imm, out_rd, out_rd_en}, {i_ADDI, 32'd5, 5'd1, 1'b1});
        step();
        in_instr = 32'h0020A223; in_pc = 32'h208;
        @(negedge clk);
        chk("stream_jal", {out_opcode, out_imm, out_rd, out_rd_en}, {i_JAL, 32'd8, 5'd1, 1'b1});
        step();
        in_valid = 0;
        @(negedge clk);
        chk("stream_sw", {out_opcode, out_rs1, out_rs2, out_imm, out_rd_en}, {i_SW, 5'd1, 5'd2, 32'd4, 1'b0});
        step();
        out_ready = 0;
        step();

        in_valid = 1; in_instr = 32'h002081B3; in_pc = 32'h300;
        step();
        in_instr = 32'h00500093; in_pc = 32'h304;
        step();
        in_instr = 32'h0020A223; in_pc = 32'h308;
        @(negedge clk);
        chk("bp_full", {in_ready, out_valid}, {1'b0, 1'b1});
        step();
        @(negedge clk);
        chk("bp_hold", {in_ready, out_opcode}, {1'b0, i_ADD});
        step();
        out_ready = 1;
        @(negedge clk);
        chk("bp_ready_comb", in_ready, 1'b1);
        step();
        in_valid = 0;
        @(negedge clk);
        chk("bp_order1", {out_opcode, out_pc}, {i_ADDI, 32'h304});
        step();
        @(negedge clk);
        chk("bp_order2", {out_opcode, out_pc}, {i_SW, 32'h308});
        step();
        out_ready = 0;
        @(negedge clk);
        chk("bp_empty", out_valid, 1'b0);
        step();

        send(32'h0000_0000, 32'h400);
        @(negedge clk);
        chk("ill_zero", {out_valid, out_opcode, out_illegal, out_rs1_en, out_rs2_en, out_rd_en, out_pc},
            {1'b1, i_NOP, 1'b1, 3'b000, 32'h400});
        pop_all();
        send(32'h02209093, 32'h404);
        @(negedge clk);
        chk("ill_slli", {out_opcode, out_illegal, out_rs1_en, out_rs2_en, out_rd_en}, {i_NOP, 1'b1, 3'b000});
        pop_all();
        send(32'h00100073, 32'h408);
        @(negedge clk);
        chk("ebreak", {out_opcode, out_illegal, out_rs1_en, out_rs2_en, out_rd_en}, {i_EBREAK, 1'b0, 3'b000});
        pop_all();

        send(32'h022081B3, 32'h40C);
        @(negedge clk);
`ifdef RV32M_EN
        chk("mul", {out_opcode, out_illegal, out_rs1_en, out_rs2_en, out_rd_en}, {i_MUL, 1'b0, 3'b111});
`else
        chk("mul_off", {out_opcode, out_illegal, out_rs1_en, out_rs2_en, out_rd_en}, {i_NOP, 1'b1, 3'b000});
`endif
        pop_all();

        foreach (misc[k]) begin
            in_valid = 1; in_instr = misc[k]; in_pc = 32'h1000 + 32'(k) * 4;
            out_ready = 1;
            step();
        end
        in_valid = 0;
        pop_all();

        idx = 0;
        for (int c = 0; c < 300 && idx < misc.size(); c++) begin
            in_valid = 1; in_instr = misc[idx]; in_pc = 32'h2000 + 32'(idx) * 4;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        in_valid = 0;
        chk("random_bp_done", idx, misc.size());
        pop_all();

        send(32'h002081B3, 32'h500);
        send(32'h00500093, 32'h504);
        flush = 1; in_valid = 1; in_instr = 32'h0020A223; in_pc = 32'h508;
        @(negedge clk);
        chk("flush_ready", {in_ready, out_valid}, {1'b0, 1'b1});
        step();
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("flush_empty", {out_valid, in_ready}, {1'b0, 1'b1});
        step();
        send(32'h00500093, 32'h50C);
        @(negedge clk);
        chk("after_flush", {out_opcode, out_pc, out_imm}, {i_ADDI, 32'h50C, 32'd5});
        pop_all();

        send(32'h002081B3, 32'h600);
        send(32'h00500093, 32'h604);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("midreset", {out_valid, in_ready, out_opcode}, {1'b0, 1'b1, i_NOP});
        #1 rst_n = 1;
        step();
        send(32'h0020A223, 32'h608);
        @(negedge clk);
        chk("after_reset", {out_opcode, out_pc}, {i_SW, 32'h608});
        pop_all();

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
